// File: rtl/pkt_dmux_nch.sv
// pkt_dmux_nch: receive-side packet demultiplexer. Classifies each packet at its head beat as
// a configuration packet for this node, a foreign configuration packet (discarded) or a data
// packet. Data packets are steered to one of NUM_CH channels, prefixed by two metadata beats,
// through a 3-cycle delay line. Keeps per-channel forwarded/dropped packet counters.
module pkt_dmux_nch #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SEL_LSB    = 120,
  parameter logic [15:0] CONF_ETYPE = 16'h9005,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_pe_clk,
  input  logic                    i_rst_n,
  input  logic [47:0]             i_pe_conf_mac,
  input  logic                    i_data_valid,
  input  logic [133:0]            i_data,
  input  logic [167:0]            i_meta,
  input  logic [NUM_CH-1:0]       i_alf,
  input  logic [NUM_CH-1:0]       i_ch_en,
  output logic [NUM_CH-1:0]       o_data_valid,
  output logic [133:0]            o_data,
  output logic                    o_data_conf_valid,
  output logic [133:0]            o_data_conf,
  output logic [7:0]              o_conf_port,
  output logic                    o_alf,
  output logic [NUM_CH*CNT_W-1:0] o_pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0]        o_busy_drop_cnt
);

  localparam logic [1:0] TagHead = 2'b01;
  localparam logic [1:0] TagTail = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StConf, StDiscard, StMeta0, StMeta1, StBody, StDrain
  } state_e;

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [63:0]                   meta_lo_q, meta_lo_d;
  logic                          tail_seen_q, tail_seen_d;
  logic                          pend_q, pend_d;
  logic                          dl1_v_q, dl2_v_q, dl_in_v;
  logic [133:0]                  dl1_q, dl2_q;
  logic [NUM_CH-1:0]             out_v_q, out_v_d;
  logic [133:0]                  out_q, out_d;
  logic                          conf_v_q, conf_v_d;
  logic [133:0]                  conf_q, conf_d;
  logic [7:0]                    port_q, port_d;
  logic [NUM_CH-1:0]             pkt_inc, drop_inc;
  logic                          busy_inc;
  logic [NUM_CH-1:0][CNT_W-1:0]  pkt_cnt_q, drop_cnt_q;
  logic [CNT_W-1:0]              busy_cnt_q;

  logic              is_head, is_tail, conf_etype, mac_hit, sel_ok, fwd_ok, post_tail, dl2_tail;
  logic [CH_W-1:0]   sel;
  logic [NUM_CH-1:0] sel_oh, ch_oh;
  logic [133:0]      meta0, meta1;

  assign is_head    = i_data_valid && (i_data[133:132] == TagHead);
  assign is_tail    = i_data_valid && (i_data[133:132] == TagTail);
  assign conf_etype = (i_data[31:16] == CONF_ETYPE);
  assign mac_hit    = (i_data[127:80] == i_pe_conf_mac);
  assign sel        = i_meta[SEL_LSB +: CH_W];
  assign sel_ok     = 32'(sel) < NUM_CH;
  assign fwd_ok     = sel_ok && i_ch_en[sel] && !i_alf[sel];
  assign sel_oh     = NUM_CH'(1) << sel;
  assign ch_oh      = NUM_CH'(1) << ch_q;
  assign meta0      = {2'b11, 4'h0, i_data[87:80], i_data[39:32], i_data[23:16], i_meta[167:64]};
  assign meta1      = {2'b11, 4'h0, 64'h0, meta_lo_q};
  assign dl2_tail   = dl2_v_q && (dl2_q[133:132] == TagTail);
  // Input tail already taken but the delayed packet is still leaving the output.
  assign post_tail  = (state_q == StDrain) || ((state_q == StMeta1) && tail_seen_q);

  // All enabled channels almost-full; a fully disabled block never reports almost-full.
  assign o_alf = (|i_ch_en) & (&(i_alf | ~i_ch_en));

  // Next-state, output-register and counter-increment decode.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    meta_lo_d   = meta_lo_q;
    tail_seen_d = tail_seen_q;
    pend_d      = pend_q;
    port_d      = port_q;
    conf_v_d    = 1'b0;
    conf_d      = conf_q;
    pkt_inc     = '0;
    drop_inc    = '0;
    busy_inc    = 1'b0;
    dl_in_v     = 1'b0;
    out_v_d     = '0;
    out_d       = '0;

    if (dl2_v_q) begin
      out_v_d = ch_oh;
      out_d   = dl2_q;
    end

    // A head arriving while draining is dropped whole; pend_q tracks its unfinished beats.
    if (post_tail) begin
      if (is_head) begin
        busy_inc = 1'b1;
        pend_d   = 1'b1;
      end else if (is_tail) begin
        pend_d   = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (is_head) begin
          meta_lo_d   = i_meta[63:0];
          tail_seen_d = 1'b0;
          pend_d      = 1'b0;
          if (conf_etype && mac_hit) begin
            state_d  = StConf;
            port_d   = i_meta[159:152];
            conf_v_d = 1'b1;
            conf_d   = i_data;
          end else if (conf_etype || !sel_ok) begin
            state_d = StDiscard;
          end else if (!fwd_ok) begin
            state_d       = StDiscard;
            drop_inc[sel] = 1'b1;
          end else begin
            state_d      = StMeta0;
            ch_d         = sel;
            pkt_inc[sel] = 1'b1;
            dl_in_v      = 1'b1;
            out_v_d      = sel_oh;
            out_d        = meta0;
          end
        end
      end
      StConf: begin
        if (i_data_valid) begin
          conf_v_d = 1'b1;
          conf_d   = i_data;
        end
        if (is_tail) state_d = StIdle;
      end
      StDiscard: begin
        if (is_tail) state_d = StIdle;
      end
      StMeta0: begin
        dl_in_v = i_data_valid;
        out_v_d = ch_oh;
        out_d   = meta1;
        if (is_tail) tail_seen_d = 1'b1;
        state_d = StMeta1;
      end
      StMeta1: begin
        if (!tail_seen_q) dl_in_v = i_data_valid;
        state_d = (tail_seen_q || is_tail) ? StDrain : StBody;
      end
      StBody: begin
        dl_in_v = i_data_valid;
        if (is_tail) state_d = StDrain;
      end
      StDrain: begin
        if (dl2_tail) state_d = pend_d ? StDiscard : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and output registers.
  always_ff @(posedge i_pe_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      meta_lo_q   <= '0;
      tail_seen_q <= 1'b0;
      pend_q      <= 1'b0;
      out_v_q     <= '0;
      out_q       <= '0;
      conf_v_q    <= 1'b0;
      conf_q      <= '0;
      port_q      <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      meta_lo_q   <= meta_lo_d;
      tail_seen_q <= tail_seen_d;
      pend_q      <= pend_d;
      out_v_q     <= out_v_d;
      out_q       <= out_d;
      conf_v_q    <= conf_v_d;
      conf_q      <= conf_d;
      port_q      <= port_d;
    end
  end

  // Two internal delay stages; the output register forms the third.
  always_ff @(posedge i_pe_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl1_v_q <= 1'b0;
      dl1_q   <= '0;
      dl2_v_q <= 1'b0;
      dl2_q   <= '0;
    end else begin
      dl1_v_q <= dl_in_v;
      dl1_q   <= i_data;
      dl2_v_q <= dl1_v_q;
      dl2_q   <= dl1_q;
    end
  end

  // Packet counters, wrapping at 2^CNT_W.
  always_ff @(posedge i_pe_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (pkt_inc[c])  pkt_cnt_q[c]  <= pkt_cnt_q[c] + 1'b1;
        if (drop_inc[c]) drop_cnt_q[c] <= drop_cnt_q[c] + 1'b1;
      end
      if (busy_inc) busy_cnt_q <= busy_cnt_q + 1'b1;
    end
  end

  assign o_data_valid      = out_v_q;
  assign o_data            = out_q;
  assign o_data_conf_valid = conf_v_q;
  assign o_data_conf       = conf_q;
  assign o_conf_port       = port_q;
  assign o_pkt_cnt         = pkt_cnt_q;
  assign o_drop_cnt        = drop_cnt_q;
  assign o_busy_drop_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_pkt_dmux_nch.sv
// tb_pkt_dmux_nch: randomized packet traffic against a packet-level reference model.
// Expected beats (with their due cycle) go into queues; a negedge monitor pops and compares.
module tb_pkt_dmux_nch;

  localparam logic [15:0] CE  = 16'h9005;
  localparam logic [47:0] MAC = 48'h0123_4567_89ab;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           i_data_valid = 1'b0;
  logic [133:0]   i_data = '0;
  logic [167:0]   i_meta = '0;
  logic [3:0]     i_alf = '0, i_ch_en = '0;
  logic [3:0]     o_data_valid;
  logic [133:0]   o_data, o_data_conf;
  logic           o_data_conf_valid, o_alf;
  logic [7:0]     o_conf_port;
  logic [127:0]   o_pkt_cnt, o_drop_cnt;
  logic [31:0]    o_busy_drop_cnt;

  pkt_dmux_nch #(.NUM_CH(4), .SEL_LSB(120), .CONF_ETYPE(CE), .CNT_W(32)) dut (
    .i_pe_clk(clk), .i_rst_n(rst_n), .i_pe_conf_mac(MAC), .i_data_valid(i_data_valid),
    .i_data(i_data), .i_meta(i_meta), .i_alf(i_alf), .i_ch_en(i_ch_en),
    .o_data_valid(o_data_valid), .o_data(o_data), .o_data_conf_valid(o_data_conf_valid),
    .o_data_conf(o_data_conf), .o_conf_port(o_conf_port), .o_alf(o_alf),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt), .o_busy_drop_cnt(o_busy_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [3:0]   oh;
    logic [133:0] data;
  } exp_t;

  exp_t        fwd_q[$];
  exp_t        conf_q[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;
  int          free_cyc = 0;
  int unsigned m_pkt[4], m_drop[4], m_busy;
  logic [7:0]  m_port;

  function automatic logic [133:0] rnd134();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[133:0];
  endfunction

  function automatic logic [167:0] rnd168();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[167:0];
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s pkt_cnt[%0d]", tag, c), o_pkt_cnt[c*32 +: 32], m_pkt[c]);
      chk($sformatf("%s drop_cnt[%0d]", tag, c), o_drop_cnt[c*32 +: 32], m_drop[c]);
    end
    chk({tag, " busy_drop_cnt"}, o_busy_drop_cnt, m_busy);
    chk({tag, " conf_port"}, o_conf_port, m_port);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_pkt[c]  = 0;
      m_drop[c] = 0;
    end
    m_busy   = 0;
    m_port   = '0;
    free_cyc = 0;
    fwd_q.delete();
    conf_q.delete();
  endtask

  task automatic drive(input logic v, input logic [133:0] d, input logic [167:0] m);
    @(posedge clk);
    #1;
    i_data_valid = v;
    i_data       = d;
    i_meta       = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rnd134(), rnd168());
  endtask

  // kind: 0 data, 1 configuration for this node, 2 configuration for another node.
  task automatic send_pkt(input int kind, input int len, input logic [1:0] sel,
                          input logic [7:0] port, input logic [3:0] alf, input logic [3:0] en,
                          input logic [3:0] alf_mid, input int gap_pct, input int post_gap);
    logic [133:0] b;
    logic [167:0] m;
    logic [3:0]   oh;
    int           t;
    bit           fwd, conf;
    b = rnd134();
    b[133:132] = 2'b01;
    m = rnd168();
    m[121:120] = sel;
    m[159:152] = port;
    oh = 4'b0001 << sel;
    if (kind == 0) begin
      if (b[31:16] == CE) b[16] = ~b[16];
    end else begin
      b[31:16]  = CE;
      b[127:80] = (kind == 1) ? MAC : (MAC ^ 48'(1 + $urandom_range(0, 1000)));
    end
    drive(1'b1, b, m);
    i_alf   = alf;
    i_ch_en = en;
    t = cyc;
    fwd  = 1'b0;
    conf = 1'b0;
    if (t < free_cyc) begin
      m_busy++;
    end else if (kind == 1) begin
      conf   = 1'b1;
      m_port = port;
    end else if (kind == 0) begin
      if (!en[sel] || alf[sel]) begin
        m_drop[sel]++;
      end else begin
        fwd = 1'b1;
        m_pkt[sel]++;
        fwd_q.push_back('{t + 1, oh,
          {2'b11, 4'h0, b[87:80], b[39:32], b[23:16], m[167:64]}});
        fwd_q.push_back('{t + 2, oh, {2'b11, 4'h0, 64'h0, m[63:0]}});
      end
    end
    if (fwd)  fwd_q.push_back('{t + 3, oh, b});
    if (conf) conf_q.push_back('{t + 1, 4'h0, b});
    for (int i = 1; i < len; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        drive(1'b0, rnd134(), rnd168());
        i_alf = alf_mid;
      end
      b = rnd134();
      b[133:132] = (i == len - 1) ? 2'b10 : 2'b11;
      drive(1'b1, b, rnd168());
      i_alf = alf_mid;
      t = cyc;
      if (fwd)  fwd_q.push_back('{t + 3, oh, b});
      if (conf) conf_q.push_back('{t + 1, 4'h0, b});
    end
    if (fwd) begin
      if (t + 3 > free_cyc) free_cyc = t + 3;
    end else begin
      if (t + 1 > free_cyc) free_cyc = t + 1;
    end
    idle(post_gap);
  endtask

  // Monitor: every presented beat must match the next expected beat, on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fwd_q.size() > 0 && fwd_q[0].cyc < cyc) begin
        mon_e = fwd_q.pop_front();
        checks++;
        errors++;
        $display("FAIL fwd_missing: got no beat by cycle %0d, expected %0h due at cycle %0d",
                 cyc, mon_e.data, mon_e.cyc);
      end
      if (o_data_valid != 4'h0) begin
        checks++;
        if (fwd_q.size() == 0) begin
          errors++;
          $display("FAIL fwd_unexpected: got valid=%b data=%0h at cycle %0d, expected none",
                   o_data_valid, o_data, cyc);
        end else begin
          mon_e = fwd_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.oh !== o_data_valid || mon_e.data !== o_data) begin
            errors++;
            $display("FAIL fwd_beat: got cyc=%0d valid=%b data=%0h, expected cyc=%0d valid=%b data=%0h",
                     cyc, o_data_valid, o_data, mon_e.cyc, mon_e.oh, mon_e.data);
          end
        end
      end
      if (conf_q.size() > 0 && conf_q[0].cyc < cyc) begin
        mon_e = conf_q.pop_front();
        checks++;
        errors++;
        $display("FAIL conf_missing: got no beat by cycle %0d, expected %0h due at cycle %0d",
                 cyc, mon_e.data, mon_e.cyc);
      end
      if (o_data_conf_valid) begin
        checks++;
        if (conf_q.size() == 0) begin
          errors++;
          $display("FAIL conf_unexpected: got data=%0h at cycle %0d, expected none",
                   o_data_conf, cyc);
        end else begin
          mon_e = conf_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.data !== o_data_conf) begin
            errors++;
            $display("FAIL conf_beat: got cyc=%0d data=%0h, expected cyc=%0d data=%0h",
                     cyc, o_data_conf, mon_e.cyc, mon_e.data);
          end
        end
      end
      checks++;
      if (o_alf !== ((i_ch_en != 4'h0) && ((i_alf | ~i_ch_en) == 4'hf))) begin
        errors++;
        $display("FAIL o_alf: got %b for alf=%b en=%b", o_alf, i_alf, i_ch_en);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [133:0] b;
    logic [167:0] m;
    model_reset();
    idle(3);
    chk("reset o_data_valid", o_data_valid, 0);
    chk("reset o_data", o_data, 0);
    chk("reset o_data_conf_valid", o_data_conf_valid, 0);
    chk("reset o_alf", o_alf, 0);
    chk_counters("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // 4-beat data packet to channel 2.
    send_pkt(0, 4, 2'd2, 8'h11, 4'h0, 4'hf, 4'h0, 0, 4);
    chk("fwd pkt_cnt[2]", o_pkt_cnt[64 +: 32], 32'd1);
    // Configuration packet for this node.
    send_pkt(1, 3, 2'd0, 8'h05, 4'h0, 4'hf, 4'h0, 0, 2);
    chk("conf o_conf_port", o_conf_port, 8'h05);
    // Foreign configuration packet, then a normal packet.
    send_pkt(2, 3, 2'd1, 8'h77, 4'h0, 4'hf, 4'h0, 0, 2);
    chk_counters("conf_mismatch");
    send_pkt(0, 3, 2'd1, 8'h00, 4'h0, 4'hf, 4'h0, 0, 4);
    // Almost-full drop, then almost-full rising mid-packet.
    send_pkt(0, 3, 2'd1, 8'h00, 4'b0010, 4'hf, 4'b0010, 0, 2);
    chk("alf drop_cnt[1]", o_drop_cnt[32 +: 32], 32'd1);
    send_pkt(0, 4, 2'd0, 8'h00, 4'b0000, 4'hf, 4'b0001, 0, 4);
    chk_counters("alf");
    // Back-to-back: head at Tt+1 dropped busy, head at Tt+3 forwarded.
    send_pkt(0, 3, 2'd3, 8'h00, 4'h0, 4'hf, 4'h0, 0, 0);
    send_pkt(0, 2, 2'd0, 8'h00, 4'h0, 4'hf, 4'h0, 0, 0);
    send_pkt(0, 3, 2'd1, 8'h00, 4'h0, 4'hf, 4'h0, 0, 5);
    chk("b2b busy_drop_cnt", o_busy_drop_cnt, 32'd1);
    chk_counters("b2b");
    idle(4);

    // Reset in the middle of a forwarded packet.
    mon_en = 1'b0;
    b = rnd134();
    b[133:132] = 2'b01;
    if (b[31:16] == CE) b[16] = ~b[16];
    m = rnd168();
    m[121:120] = 2'd0;
    drive(1'b1, b, m);
    i_alf   = 4'h0;
    i_ch_en = 4'hf;
    b[133:132] = 2'b11;
    drive(1'b1, b, rnd168());
    drive(1'b1, b, rnd168());
    #2;
    chk("rst meta1 valid", o_data_valid, 4'b0001);
    chk("rst meta1 low", o_data[63:0], m[63:0]);
    chk("rst meta1 top", o_data[133:128], 6'b110000);
    i_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst o_data_valid", o_data_valid, 0);
    chk("rst o_data", o_data, 0);
    chk("rst o_pkt_cnt", o_pkt_cnt, 0);
    chk("rst o_drop_cnt", o_drop_cnt, 0);
    chk("rst o_busy", o_busy_drop_cnt, 0);
    chk("rst o_conf_port", o_conf_port, 0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, b, rnd168());
    b[133:132] = 2'b10;
    drive(1'b1, b, rnd168());
    idle(5);
    chk_counters("post_reset");

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int          r;
      logic [3:0]  en, alf;
      r   = $urandom_range(0, 99);
      en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      alf = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      send_pkt((r < 15) ? 1 : (r < 25) ? 2 : 0, $urandom_range(2, 6), 2'($urandom),
               8'($urandom), alf, en, 4'($urandom), 20, $urandom_range(0, 3));
    end
    idle(10);
    chk("end fwd_q empty", 32'(fwd_q.size()), 0);
    chk("end conf_q empty", 32'(conf_q.size()), 0);
    chk_counters("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
